// File: rtl/dffr_pipe_pkg.sv
// dffr_pipe_pkg: shared constants and helpers for the scannable reset pipeline bank
package dffr_pipe_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;
  function automatic int chain_len(input int width, input int depth);
    return depth * (width + 1);
  endfunction
endpackage

// File: rtl/dffr_pipe_stage.sv
// dffr_pipe_stage: one pipeline stage (data word plus valid tag) with advance/hold/shift and async reset
module dffr_pipe_stage import dffr_pipe_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             ck,
  input  logic             rn,
  input  logic             en,
  input  logic             se,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             v
);
  // s[0] is scan-nearest to si, s[WIDTH] is the tag and the stage's scan exit
  logic [WIDTH:0] s, s_nxt;
  always_comb s_nxt = se ? {s[WIDTH-1:0], si} : en ? {dv, d} : s;
  always_ff @(posedge ck or negedge rn)
    if (!rn) s <= {1'b0, RESET_VAL};
    else s <= s_nxt;
  assign q = s[WIDTH-1:0];
  assign v = s[WIDTH];
endmodule

// File: rtl/dffr_pipe_bank.sv
// dffr_pipe_bank: DEPTH-stage valid-tagged pipeline with async active-low reset and a full scan chain
module dffr_pipe_bank import dffr_pipe_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             QV,
  output logic             SO
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_param
    $error("dffr_pipe_bank: WIDTH/DEPTH out of range");
  end
  // element k feeds stage k; element k+1 is stage k's registered output
  logic [WIDTH-1:0] dch [DEPTH+1];
  logic             vch [DEPTH+1];
  assign dch[0] = D;
  assign vch[0] = DV;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dffr_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .ck(CK),
      .rn(RN),
      .en(EN),
      .se(SE),
      .d(dch[k]),
      .dv(vch[k]),
      .si(k == 0 ? SI : vch[k]),
      .q(dch[k+1]),
      .v(vch[k+1])
    );
  end
  assign Q  = dch[DEPTH];
  assign QN = ~dch[DEPTH];
  assign QV = vch[DEPTH];
  assign SO = vch[DEPTH];
endmodule

// File: tb/tb_dffr_pipe_bank.sv
// tb_dffr_pipe_bank: randomized bench for two dffr_pipe_bank configurations against a word/bit-list model
module tb_dffr_pipe_bank;
  typedef struct {
    logic [63:0] d [16];
    logic        v [16];
  } mstate_t;
  logic CK;
  logic a_rn, a_dv, a_en, a_se, a_si, a_qv, a_so;
  logic [7:0] a_d, a_q, a_qn;
  logic b_rn, b_dv, b_en, b_se, b_si, b_qv, b_so;
  logic [3:0] b_d, b_q, b_qn;
  int total, bad;
  mstate_t ma, mb;
  dffr_pipe_bank #(.WIDTH(8), .DEPTH(2)) dut_a (
    .CK(CK), .RN(a_rn), .D(a_d), .DV(a_dv), .EN(a_en), .SE(a_se), .SI(a_si),
    .Q(a_q), .QN(a_qn), .QV(a_qv), .SO(a_so)
  );
  dffr_pipe_bank #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h9)) dut_b (
    .CK(CK), .RN(b_rn), .D(b_d), .DV(b_dv), .EN(b_en), .SE(b_se), .SI(b_si),
    .Q(b_q), .QN(b_qn), .QV(b_qv), .SO(b_so)
  );
  initial CK = 1'b0;
  always #5 CK = ~CK;
  function automatic mstate_t mreset(input logic [63:0] rv);
    mstate_t r;
    for (int k = 0; k < 16; k++) begin
      r.d[k] = rv;
      r.v[k] = 1'b0;
    end
    return r;
  endfunction
  // shift treats the whole bank as one flat bit list ordered from SI to SO
  function automatic mstate_t mnext(input mstate_t s, input int w, input int dp, input logic se,
                                    input logic en, input logic si, input logic dv, input logic [63:0] d);
    mstate_t r = s;
    logic c [$];
    if (se) begin
      for (int k = 0; k < dp; k++) begin
        for (int b = 0; b < w; b++) c.push_back(s.d[k][b]);
        c.push_back(s.v[k]);
      end
      c.push_front(si);
      void'(c.pop_back());
      for (int k = 0; k < dp; k++) begin
        for (int b = 0; b < w; b++) r.d[k][b] = c.pop_front();
        r.v[k] = c.pop_front();
      end
    end else if (en) begin
      for (int k = dp - 1; k > 0; k--) begin
        r.d[k] = s.d[k-1];
        r.v[k] = s.v[k-1];
      end
      r.d[0] = d & ((64'd1 << w) - 64'd1);
      r.v[0] = dv;
    end
    return r;
  endfunction
  always @(posedge CK or negedge a_rn)
    if (!a_rn) ma <= mreset(64'h0);
    else ma <= mnext(ma, 8, 2, a_se, a_en, a_si, a_dv, {56'b0, a_d});
  always @(posedge CK or negedge b_rn)
    if (!b_rn) mb <= mreset(64'h9);
    else mb <= mnext(mb, 4, 1, b_se, b_en, b_si, b_dv, {60'b0, b_d});
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge CK) begin
    chk("a_q", {56'b0, a_q}, ma.d[1]);
    chk("a_qn", {56'b0, a_qn}, {56'b0, ~ma.d[1][7:0]});
    chk("a_qv", {63'b0, a_qv}, {63'b0, ma.v[1]});
    chk("a_so", {63'b0, a_so}, {63'b0, ma.v[1]});
    chk("b_q", {60'b0, b_q}, mb.d[0]);
    chk("b_qn", {60'b0, b_qn}, {60'b0, ~mb.d[0][3:0]});
    chk("b_qv", {63'b0, b_qv}, {63'b0, mb.v[0]});
    chk("b_so", {63'b0, b_so}, {63'b0, mb.v[0]});
  end
  task automatic tick();
    @(negedge CK);
    #1;
  endtask
  initial begin
    total = 0;
    bad = 0;
    {a_dv, a_en, a_se, a_si, a_d} = '0;
    {b_dv, b_en, b_se, b_si, b_d} = '0;
    a_rn = 1'b1;
    b_rn = 1'b1;
    #1;
    a_rn = 1'b0;
    b_rn = 1'b0;
    #1;
    chk("rst_a_q", {56'b0, a_q}, 64'h00);
    chk("rst_a_qn", {56'b0, a_qn}, 64'hFF);
    chk("rst_a_qv", {63'b0, a_qv}, 64'h0);
    chk("rst_a_so", {63'b0, a_so}, 64'h0);
    chk("rst_b_q", {60'b0, b_q}, 64'h9);
    chk("rst_b_qn", {60'b0, b_qn}, 64'h6);
    #1;
    a_rn = 1'b1;
    b_rn = 1'b1;
    repeat (3) tick();
    chk("idle_a_q", {56'b0, a_q}, 64'h00);
    chk("idle_a_qn", {56'b0, a_qn}, 64'hFF);
    chk("idle_a_qv", {63'b0, a_qv}, 64'h0);
    chk("idle_a_so", {63'b0, a_so}, 64'h0);
    chk("idle_b_q", {60'b0, b_q}, 64'h9);
    a_en = 1; a_d = 8'hA5; a_dv = 1;
    b_en = 1; b_d = 4'h2; b_dv = 1;
    tick();
    chk("b_lat1_q", {60'b0, b_q}, 64'h2);
    chk("b_lat1_qn", {60'b0, b_qn}, 64'hD);
    b_en = 0;
    a_d = 8'h3C;
    tick();
    chk("lat_a5_q", {56'b0, a_q}, 64'hA5);
    chk("lat_a5_qv", {63'b0, a_qv}, 64'h1);
    a_d = 8'h00; a_dv = 0;
    tick();
    chk("lat_3c_q", {56'b0, a_q}, 64'h3C);
    a_d = 8'h5A; a_dv = 1;
    tick();
    a_en = 0; a_d = 8'hFF; a_dv = 0;
    repeat (4) tick();
    chk("hold_q", {56'b0, a_q}, 64'h00);
    chk("hold_qv", {63'b0, a_qv}, 64'h0);
    a_en = 1; a_d = 8'h00; a_dv = 0;
    tick();
    chk("hold_5a_q", {56'b0, a_q}, 64'h5A);
    chk("hold_5a_qv", {63'b0, a_qv}, 64'h1);
    // pattern 1,0,1,1 repeating; EN/D toggle randomly and must be ignored
    a_se = 1;
    for (int i = 0; i < 18; i++) begin
      a_si = (i % 4) != 1;
      a_en = 1'($urandom);
      a_d = 8'($urandom);
      a_dv = 1'($urandom);
      tick();
      if (i == 16) chk("shift_so_e17", {63'b0, a_so}, 64'h0);
    end
    chk("shift_so_e18", {63'b0, a_so}, 64'h1);
    chk("shift_q", {56'b0, a_q}, 64'h77);
    chk("shift_qv", {63'b0, a_qv}, 64'h1);
    a_se = 0;
    b_en = 1; b_d = 4'h0; b_dv = 0;
    tick();
    b_en = 0;
    b_se = 1;
    for (int i = 0; i < 5; i++) begin
      b_si = i == 0;
      tick();
      if (i == 3) chk("b_chain_e4", {63'b0, b_so}, 64'h0);
      if (i == 4) chk("b_chain_e5", {63'b0, b_so}, 64'h1);
    end
    chk("b_chain_len", 64'(dffr_pipe_pkg::chain_len(4, 1)), 64'd5);
    b_se = 0;
    a_en = 1; a_d = 8'hFF; a_dv = 1;
    repeat (2) tick();
    chk("ff_q", {56'b0, a_q}, 64'hFF);
    chk("ff_qv", {63'b0, a_qv}, 64'h1);
    a_en = 0;
    #2;
    a_rn = 1'b0;
    #1;
    chk("async_q", {56'b0, a_q}, 64'h00);
    chk("async_qn", {56'b0, a_qn}, 64'hFF);
    chk("async_qv", {63'b0, a_qv}, 64'h0);
    chk("async_so", {63'b0, a_so}, 64'h0);
    a_se = 1; a_si = 1; a_en = 1; a_d = 8'hC3; a_dv = 1;
    tick();
    chk("inrst_q", {56'b0, a_q}, 64'h00);
    chk("inrst_so", {63'b0, a_so}, 64'h0);
    a_rn = 1'b1;
    a_se = 0; a_en = 0;
    repeat (400) begin
      a_se = $urandom_range(0, 7) == 0;
      a_en = 1'($urandom);
      a_d = 8'($urandom);
      a_dv = 1'($urandom);
      a_si = 1'($urandom);
      b_se = $urandom_range(0, 7) == 0;
      b_en = 1'($urandom);
      b_d = 4'($urandom);
      b_dv = 1'($urandom);
      b_si = 1'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        a_rn = 1'b0;
        #2;
        a_rn = 1'b1;
      end
      if ($urandom_range(0, 30) == 0) begin
        b_rn = 1'b0;
        #1;
        b_rn = 1'b1;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dffr_pipe_bank.md
DFFR_PIPE_BANK -- requirements
Module: dffr_pipe_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 2: number of pipeline stages; legal range 1..16.
REQ-003 Parameter RESET_VAL, default all-zero (WIDTH bits): data value loaded into every stage on reset.
REQ-004 CK  input  1  single clock; all state updates on the rising edge.
REQ-005 RN  input  1  reset, asynchronous and active-low.
REQ-006 D   input  WIDTH  functional data into stage 0.
REQ-007 DV  input  1  valid tag accompanying D.
REQ-008 EN  input  1  advance enable; 0 holds all stages.
REQ-009 SE  input  1  scan enable; 1 selects shift mode.
REQ-010 SI  input  1  scan serial input.
REQ-011 Q   output WIDTH  data of stage DEPTH-1.
REQ-012 QN  output WIDTH  bitwise inverse of Q.
REQ-013 QV  output 1  valid tag of stage DEPTH-1.
REQ-014 SO  output 1  scan serial output.

Function
REQ-015 State: DEPTH stages, each holding a WIDTH-bit data word data[k] and a 1-bit tag v[k]; k=0 is the input stage.
REQ-016 Mode priority per rising CK edge with RN=1: SE=1 selects shift; else EN=1 selects advance; else hold.
REQ-017 Advance: data[0]<=D, v[0]<=DV, and data[k]<=data[k-1], v[k]<=v[k-1] for k=1..DEPTH-1, all in the same edge.
REQ-018 Hold: every bit retains its value; D, DV, SI are ignored.
REQ-019 Latency: a word presented with EN=1 appears on Q/QV after exactly DEPTH advancing edges; hold cycles in between add no loss and no duplication.
REQ-020 Scan chain order, from SI to SO: data[0][0], data[0][1], ..., data[0][WIDTH-1], v[0], data[1][0], ..., v[DEPTH-1]; chain length DEPTH*(WIDTH+1).
REQ-021 Shift: SI enters data[0][0], each bit moves one position toward SO, and the old value of v[DEPTH-1] is lost; EN, D, DV are ignored.
REQ-022 SO = v[DEPTH-1] combinationally from state; SO is valid in all modes.
REQ-023 Q, QN, QV are driven directly from stage DEPTH-1 registers, with no combinational path from D, DV, EN, SE or SI.
REQ-024 DEPTH=1: stage 0 is also the output stage, and chain length is WIDTH+1.
REQ-025 SE or EN change in the same cycle: the mode is sampled at the edge only; no partial-stage updates.
REQ-026 X on EN or SE with RN=1: all state bits become X at that edge, which is pessimistic; X on RN is treated as reset for any bit whose reset value equals its current value, and X otherwise.

Reset
REQ-027 RN=0 immediately, without CK, forces data[k]=RESET_VAL and v[k]=0 for all k; Q=RESET_VAL, QN=~RESET_VAL, QV=0, SO=0.
REQ-028 While RN=0, CK edges have no effect in any mode.
REQ-029 Release of RN between edges: the first rising CK edge after release performs a normal update; reset during a shift sequence discards the partially shifted chain.

Structure
REQ-030 Package dffr_pipe_pkg shall hold the default WIDTH/DEPTH constants, the legal-range limits, and a function returning the chain length DEPTH*(WIDTH+1).
REQ-031 Sub-module dffr_pipe_stage shall implement one stage (WIDTH data bits plus tag, with advance/hold/shift muxing and async reset); the top shall instantiate it DEPTH times via generate.
REQ-032 Out-of-range parameters shall be rejected at elaboration.

Verification
REQ-033 WIDTH=8, DEPTH=2: RN=0 then release; Q=8'h00, QN=8'hFF, QV=0, SO=0 immediately and after 3 idle edges.
REQ-034 EN=1 with D=8'hA5,DV=1 then D=8'h3C,DV=1 -> Q=8'hA5,QV=1 after edge 2 and Q=8'h3C after edge 3; inserting EN=0 for 4 cycles delays the output by exactly 4 edges.
REQ-035 SE=1, shift pattern 1,0,1,1,... for 18 edges (WIDTH=8,DEPTH=2) -> SO emits the first SI bit on edge 18 and the prior chain contents in order on edges 1-17; SE=1 with EN=1 performs a shift only.
REQ-036 Load 8'hFF,DV=1 into both stages, then pulse RN low mid-cycle with CK idle -> Q=8'h00 and QV=0 within the same cycle, with no edge required.
REQ-037 DEPTH=1, WIDTH=4, RESET_VAL=4'h9: reset gives Q=4'h9, QN=4'h6; EN with D=4'h2 gives Q=4'h2 after 1 edge; the chain length is 5.
